// File: rtl/memory_responder_pkg.sv
// Shared constants for the dual-port memory responder: default word width,
// per-port FSM state encoding and the request-decode helper.
package memory_responder_pkg;

    localparam int unsigned WORD_SIZE_DEFAULT = 16;
    localparam int unsigned CNT_W             = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } port_state_e;

    // A request is only meaningful when exactly one of read/write is asserted.
    function automatic logic req_valid(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// One memory port: IDLE/BUSY/DONE sequencer with latency down-counter and
// request latches (op, address, write data).
module mem_port_fsm
    import memory_responder_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT,
    parameter int unsigned LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_m,
    input  logic                 write_m,
    input  logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] bus_in,
    output logic                 ready,
    output logic                 rd_done,
    output logic                 wr_done,
    output logic [WORD_SIZE-1:0] addr_out,
    output logic [WORD_SIZE-1:0] data_out
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    port_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_rd_q, op_rd_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 ready_q, ready_d;

    // Next-state, counter and request-latch logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_rd_d = op_rd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid(read_m, write_m)) begin
                    op_rd_d = read_m;
                    addr_d  = address;
                    data_d  = write_m ? bus_in : data_q;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? ST_DONE : ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Entering DONE on the edge where the count reaches zero.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_DONE);
    end

    // State, counter and latch registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_rd_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_rd_q <= op_rd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign rd_done  = ready_q & op_rd_q;
    assign wr_done  = ready_q & ~op_rd_q;
    assign addr_out = addr_q;
    assign data_out = data_q;

endmodule

// File: rtl/memory_responder.sv
// Dual-port (instruction/data) memory model with fixed access latency over a
// single shared array; data-port writes win same-index collisions.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEFAULT,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_readM,
    input  logic                 i_writeM,
    input  logic [WORD_SIZE-1:0] i_address,
    inout  wire  [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    inout  wire  [WORD_SIZE-1:0] d_data,
    output logic                 d_ready
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    logic                 i_rd_done, i_wr_done, d_rd_done, d_wr_done;
    logic [WORD_SIZE-1:0] i_addr, d_addr, i_wdata, d_wdata;
    logic [AW-1:0]        i_idx, d_idx;
    logic [WORD_SIZE-1:0] mem_q [MEM_DEPTH];
    logic                 unused_addr_hi;

    mem_port_fsm #(.WORD_SIZE(WORD_SIZE), .LATENCY(LATENCY)) u_i_port (
        .clk(clk), .reset(reset), .read_m(i_readM), .write_m(i_writeM),
        .address(i_address), .bus_in(i_data), .ready(i_ready),
        .rd_done(i_rd_done), .wr_done(i_wr_done),
        .addr_out(i_addr), .data_out(i_wdata)
    );

    mem_port_fsm #(.WORD_SIZE(WORD_SIZE), .LATENCY(LATENCY)) u_d_port (
        .clk(clk), .reset(reset), .read_m(d_readM), .write_m(d_writeM),
        .address(d_address), .bus_in(d_data), .ready(d_ready),
        .rd_done(d_rd_done), .wr_done(d_wr_done),
        .addr_out(d_addr), .data_out(d_wdata)
    );

    // Addresses wrap modulo MEM_DEPTH; the upper bits are deliberately dropped.
    assign i_idx          = i_addr[AW-1:0];
    assign d_idx          = d_addr[AW-1:0];
    assign unused_addr_hi = ^{i_addr[WORD_SIZE-1:AW], d_addr[WORD_SIZE-1:AW]};

    // Array commit at the end of DONE; the later data-port write takes priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (i_wr_done) begin
                mem_q[i_idx] <= i_wdata;
            end
            if (d_wr_done) begin
                mem_q[d_idx] <= d_wdata;
            end
        end
    end

    assign i_data = i_rd_done ? mem_q[i_idx] : {WORD_SIZE{1'bz}};
    assign d_data = d_rd_done ? mem_q[d_idx] : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: LATENCY=4 instance for the main
// traffic and a LATENCY=1 instance for back-to-back acceptance.
module tb_memory_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        i_readM, i_writeM, d_readM, d_writeM;
    logic [15:0] i_address, d_address;
    wire  [15:0] i_data, d_data;
    logic        i_ready, d_ready;
    logic        i_oe, d_oe;
    logic [15:0] i_drv, d_drv;

    assign i_data = i_oe ? i_drv : 16'hzzzz;
    assign d_data = d_oe ? d_drv : 16'hzzzz;

    logic        u_i_readM, u_i_writeM, u_d_readM, u_d_writeM;
    logic [15:0] u_i_address, u_d_address;
    wire  [15:0] u_i_data, u_d_data;
    logic        u_i_ready, u_d_ready;

    memory_responder #(.WORD_SIZE(16), .MEM_DEPTH(256), .LATENCY(4)) dut (
        .clk(clk), .reset(reset),
        .i_readM(i_readM), .i_writeM(i_writeM), .i_address(i_address),
        .i_data(i_data), .i_ready(i_ready),
        .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address),
        .d_data(d_data), .d_ready(d_ready)
    );

    memory_responder #(.WORD_SIZE(16), .MEM_DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .i_readM(u_i_readM), .i_writeM(u_i_writeM), .i_address(u_i_address),
        .i_data(u_i_data), .i_ready(u_i_ready),
        .d_readM(u_d_readM), .d_writeM(u_d_writeM), .d_address(u_d_address),
        .d_data(u_d_data), .d_ready(u_d_ready)
    );

    typedef struct {
        int          due;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor: ready must match the queue head's due cycle exactly.
    bit   exp_i, exp_d;
    exp_t e_i, e_d;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_i = (iq.size() > 0) && (iq[0].due == cyc);
            exp_d = (dq.size() > 0) && (dq[0].due == cyc);
            check_eq("i_ready", {31'd0, i_ready}, {31'd0, exp_i});
            check_eq("d_ready", {31'd0, d_ready}, {31'd0, exp_d});
            if (exp_i) begin
                e_i = iq.pop_front();
                if (e_i.rd) check_eq("i_rdata", {16'd0, i_data}, {16'd0, e_i.data});
            end
            if (exp_d) begin
                e_d = dq.pop_front();
                if (e_d.rd) check_eq("d_rdata", {16'd0, d_data}, {16'd0, e_d.data});
            end
        end
    end

    task automatic set_req(input bit pd, input bit rd, input logic [15:0] a, input logic [15:0] v);
        exp_t e;
        e.due  = cyc + 4;
        e.rd   = rd;
        e.data = v;
        if (pd) begin
            d_readM = rd; d_writeM = ~rd; d_address = a;
            d_oe = ~rd;   d_drv = v;
            dq.push_back(e);
        end else begin
            i_readM = rd; i_writeM = ~rd; i_address = a;
            i_oe = ~rd;   i_drv = v;
            iq.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i_readM = 1'b0; i_writeM = 1'b0; i_oe = 1'b0;
        d_readM = 1'b0; d_writeM = 1'b0; d_oe = 1'b0;
    endtask

    task automatic do_op(input bit pd, input bit rd, input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        set_req(pd, rd, a, v);
        tick();
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        i_readM = 1'b0; i_writeM = 1'b0; i_address = 16'h0; i_oe = 1'b0; i_drv = 16'h0;
        d_readM = 1'b0; d_writeM = 1'b0; d_address = 16'h0; d_oe = 1'b0; d_drv = 16'h0;
        u_i_readM = 1'b0; u_i_writeM = 1'b0; u_i_address = 16'h0;
        u_d_readM = 1'b0; u_d_writeM = 1'b0; u_d_address = 16'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_eq("rst_u_i_ready", {31'd0, u_i_ready}, 32'd0);
        check_eq("rst_u_d_ready", {31'd0, u_d_ready}, 32'd0);

        // Data-port write with the bench holding the bus: the DUT must not drive it.
        @(negedge clk);
        set_req(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        @(posedge clk);
        #1 d_writeM = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("wr_bus_hiz", {16'd0, d_data}, 32'h0000BEEF);
        end
        d_oe = 1'b0;
        repeat (2) @(negedge clk);
        do_op(1'b1, 1'b1, 16'h0010, 16'hBEEF);

        // Simultaneous reads from both ports.
        do_op(1'b0, 1'b0, 16'h0003, 16'h1234);
        @(negedge clk);
        set_req(1'b0, 1'b1, 16'h0003, 16'h1234);
        set_req(1'b1, 1'b1, 16'h0003, 16'h1234);
        tick();
        repeat (5) @(negedge clk);

        // Same-index writes from both ports: data port wins.
        @(negedge clk);
        set_req(1'b0, 1'b0, 16'h0020, 16'h1111);
        set_req(1'b1, 1'b0, 16'h0020, 16'h2222);
        tick();
        repeat (5) @(negedge clk);
        do_op(1'b0, 1'b1, 16'h0020, 16'h2222);

        // Read and write DONE together on one index: read sees the old word.
        do_op(1'b0, 1'b0, 16'h0040, 16'h5555);
        @(negedge clk);
        set_req(1'b0, 1'b1, 16'h0040, 16'h5555);
        set_req(1'b1, 1'b0, 16'h0040, 16'h6666);
        tick();
        repeat (5) @(negedge clk);
        do_op(1'b1, 1'b1, 16'h0040, 16'h6666);

        // Read and write both high: ignored for the whole hold window.
        @(negedge clk);
        d_readM = 1'b1; d_writeM = 1'b1; d_address = 16'h0050;
        d_oe = 1'b1; d_drv = 16'hC3C3;
        repeat (8) begin
            @(negedge clk);
            check_eq("collide_bus", {16'd0, d_data}, 32'h0000C3C3);
        end
        d_readM = 1'b0; d_writeM = 1'b0; d_oe = 1'b0;
        do_op(1'b1, 1'b1, 16'h0050, 16'h0000);

        // Address wrap modulo depth.
        do_op(1'b1, 1'b0, 16'h0105, 16'h7777);
        do_op(1'b0, 1'b1, 16'h0005, 16'h7777);

        // Reset two edges after accepting a write; a request during reset is ignored.
        @(negedge clk);
        set_req(1'b1, 1'b0, 16'h0030, 16'hAAAA);
        tick();
        @(negedge clk);
        reset = 1'b1;
        dq.delete();
        i_readM = 1'b1; i_address = 16'h0010;
        @(posedge clk);
        #1 reset = 1'b0;
        i_readM = 1'b0;
        repeat (6) @(negedge clk);
        do_op(1'b1, 1'b1, 16'h0030, 16'h0000);
        do_op(1'b0, 1'b1, 16'h0010, 16'hBEEF);

        // LATENCY=1 instance: request held four cycles gives ready at T+1 and T+3.
        @(negedge clk);
        u_d_readM = 1'b1; u_d_address = 16'h0010;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            check_eq($sformatf("l1_ready_%0d", j), {31'd0, u_d_ready}, {31'd0, (j == 1 || j == 3)});
            if (j == 1) check_eq("l1_rdata", {16'd0, u_d_data}, 32'd0);
            if (j == 4) u_d_readM = 1'b0;
        end

        repeat (3) @(negedge clk);
        check_eq("iq_drained", iq.size(), 32'd0);
        check_eq("dq_drained", dq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter WORD_SIZE, default 16: width of address and data words.
REQ-002 Parameter MEM_DEPTH, default 256: number of words, power of two.
REQ-003 Parameter LATENCY, default 4, legal range 1..15: cycles from request acceptance to ready.
REQ-004 clk  input  1: single clock, all state updates on rising edge.
REQ-005 reset  input  1: reset, synchronous and active-high.
REQ-006 i_readM  input  1: instruction-port read request.
REQ-007 i_writeM  input  1: instruction-port write request.
REQ-008 i_address  input  WORD_SIZE: instruction-port word address.
REQ-009 i_data  inout  WORD_SIZE: instruction-port data bus, bidirectional.
REQ-010 i_ready  output  1: instruction-port completion pulse.
REQ-011 d_readM  input  1: data-port read request.
REQ-012 d_writeM  input  1: data-port write request.
REQ-013 d_address  input  WORD_SIZE: data-port word address.
REQ-014 d_data  inout  WORD_SIZE: data-port data bus, bidirectional.
REQ-015 d_ready  output  1: data-port completion pulse.

Function
REQ-016 Each port SHALL run an independent FSM with states IDLE, BUSY, DONE over one shared storage array.
REQ-017 In IDLE, exactly one of readM/writeM high SHALL accept the request at that edge (cycle T): latch op, address and, for writes, bus data; load a down-counter with LATENCY-1; go to BUSY, or directly to DONE when LATENCY=1.
REQ-018 readM and writeM both high in IDLE SHALL be ignored; the FSM stays IDLE and ready stays low.
REQ-019 BUSY SHALL decrement the counter each cycle and go to DONE when it reaches 0.
REQ-020 ready SHALL be high only in DONE, i.e. exactly cycle T+LATENCY, for exactly one cycle; DONE always returns to IDLE next cycle.
REQ-021 Read: during DONE the port SHALL drive the array word at the latched address onto its data bus, sampled from the array in that cycle.
REQ-022 Write: the latched data SHALL commit to the array at the end edge of the DONE cycle.
REQ-023 The data bus SHALL be high-Z in every cycle except a read DONE cycle.
REQ-024 Request inputs in BUSY/DONE SHALL be ignored; a request still held in the cycle after DONE SHALL be accepted as new.
REQ-025 Array index SHALL be address modulo MEM_DEPTH (low log2(MEM_DEPTH) bits); no error for high bits.
REQ-026 Both ports writing the same index in the same DONE cycle: data-port value SHALL win.
REQ-027 Read DONE and write DONE on the same index in the same cycle: the read SHALL return the pre-write value.

Reset
REQ-028 reset high at an edge SHALL force both FSMs to IDLE, counters to 0, i_ready=d_ready=0, both buses high-Z.
REQ-029 An in-flight write SHALL be discarded by reset; array contents SHALL NOT be altered by reset (all-zero at time 0).
REQ-030 No request SHALL be accepted in a cycle where reset is high.

Structure
REQ-031 WORD_SIZE default and the FSM state encoding SHALL live in the shared constants include.
REQ-032 The per-port FSM, counter and latches SHALL be one sub-module, mem_port_fsm, instantiated twice; the array and write-priority arbitration stay in memory_responder.

Verification
REQ-033 LATENCY=4; d_writeM, addr 0x0010, data 0xBEEF at T -> d_ready high only at T+4, d_data high-Z throughout driver-side check; later d_readM 0x0010 -> 0xBEEF on d_data with d_ready.
REQ-034 i_readM 0x0003 and d_readM 0x0003 same cycle, array holds 0x1234 -> both ready at T+4, both buses 0x1234.
REQ-035 Both ports write addr 0x0020 same cycle, i=0x1111, d=0x2222 -> subsequent read returns 0x2222.
REQ-036 d_readM and d_writeM both high -> no d_ready for 8 cycles, bus high-Z; address 0x0105 with MEM_DEPTH=256 write then read 0x0005 -> same data.
REQ-037 Write 0xAAAA to 0x0030 accepted, reset at T+2 -> no ready; read 0x0030 returns prior value 0x0000.
REQ-038 LATENCY=1; d_readM held high 4 cycles -> d_ready at T+1 and T+3, low at T+2.
